// File: rtl/regfile_bypass_sb_pkg.sv
// Shared definitions for the ID-stage register file with bypass and scoreboard.
package regfile_pkg;

  // Address width for a register file of nregs entries (at least one bit).
  function automatic int addr_w(input int nregs);
    return (nregs > 2) ? $clog2(nregs) : 1;
  endfunction

  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = addr_w(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  // Register 0 reads as zero, ignores writes and is never marked busy.
  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_bypass_sb_if.sv
// Operand-read, write-back, issue and status bundle between the ID stage and the register file.
interface regfile_bypass_sb_if #(
  parameter int N     = 32,
  parameter int NREGS = 32,
  parameter int NR    = 2,
  parameter int CW    = 16,
  parameter int AW    = regfile_pkg::addr_w(NREGS)
);
  logic [NR-1:0]         rd_en;
  logic [NR-1:0][AW-1:0] rd_addr;
  logic [NR-1:0][N-1:0]  rd_data;
  logic [NR-1:0]         rd_ready;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [N-1:0]          wr_data;
  logic                  issue_en;
  logic [AW-1:0]         issue_addr;
  logic                  flush;
  logic                  stall;
  logic [NREGS-1:0]      busy_vec;
  logic [CW-1:0]         stall_cnt;

  // The pipeline side requests operands, writes back and issues producers.
  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    input  rd_data, rd_ready, stall, busy_vec, stall_cnt
  );

  // The register file answers with operands and hazard status.
  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    output rd_data, rd_ready, stall, busy_vec, stall_cnt
  );
endinterface

// File: rtl/regfile_bypass_sb_wb_bypass_port.sv
// One operand read port: zero register, same-cycle write-back bypass, or storage with busy check.
module wb_bypass_port
  import regfile_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] addr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [N-1:0]  reg_data,
  input  logic          reg_busy,
  output logic [N-1:0]  rd_data,
  output logic          rd_ready
);

  // Select the operand source; a write landing this cycle also satisfies a pending producer.
  always_comb begin
    rd_data  = reg_data;
    rd_ready = !reg_busy;
    if (addr == AW'(REG_ZERO)) begin
      rd_data  = '0;
      rd_ready = 1'b1;
    end else if (wr_en && (wr_addr == addr)) begin
      rd_data  = wr_data;
      rd_ready = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Register file with write-back bypass, busy-bit scoreboard and saturating stall counter.
module regfile_bypass_sb
  import regfile_pkg::*;
#(
  parameter int N     = 32,
  parameter int NREGS = 32,
  parameter int NR    = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  regfile_bypass_sb_if.slave bus
);

  localparam int AW = addr_w(NREGS);

  logic [N-1:0]         regs_q [NREGS];
  logic [N-1:0]         regs_d [NREGS];
  logic [NREGS-1:0]     busy_q;
  logic [NREGS-1:0]     busy_d;
  logic [CW-1:0]        stall_cnt_q;
  logic [CW-1:0]        stall_cnt_d;
  logic [NR-1:0][N-1:0] stor_data;
  logic [NR-1:0][N-1:0] rd_data_w;
  logic [NR-1:0]        rd_ready_w;
  logic                 stall_w;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  for (genvar i = 0; i < NR; i++) begin : g_port
    assign stor_data[i] = regs_q[bus.rd_addr[i]];

    wb_bypass_port #(.N(N), .AW(AW)) u_port (
      .addr     (bus.rd_addr[i]),
      .wr_en    (bus.wr_en),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data),
      .reg_data (stor_data[i]),
      .reg_busy (busy_q[bus.rd_addr[i]]),
      .rd_data  (rd_data_w[i]),
      .rd_ready (rd_ready_w[i])
    );
  end

  // A disabled port never stalls, even if it points at a busy register.
  assign stall_w       = |(bus.rd_en & ~rd_ready_w);
  assign bus.rd_data   = rd_data_w;
  assign bus.rd_ready  = rd_ready_w;
  assign bus.stall     = stall_w;
  assign bus.busy_vec  = busy_q;
  assign bus.stall_cnt = stall_cnt_q;

  // Write-back into storage; register 0 is never written so it stays zero.
  always_comb begin
    regs_d = regs_q;
    if (bus.wr_en && (bus.wr_addr != AW'(REG_ZERO))) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Scoreboard: flush wins, then a new producer, then a write-back clears the bit.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (bus.flush) begin
        busy_d[r] = 1'b0;
      end else if (bus.issue_en && (bus.issue_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (bus.wr_en && (bus.wr_addr == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Count stalled cycles, holding at the maximum instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_w) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q      <= '{default: '0};
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_bypass_sb;
  import regfile_pkg::*;

  localparam int N     = 32;
  localparam int NREGS = 32;
  localparam int NR    = 2;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic rst2 = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_bypass_sb_if #(.N(N), .NREGS(NREGS), .NR(NR), .CW(CW)) bus ();
  regfile_bypass_sb_if #(.N(N), .NREGS(NREGS), .NR(NR), .CW(2))  bus2 ();

  regfile_bypass_sb #(.N(N), .NREGS(NREGS), .NR(NR), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  regfile_bypass_sb #(.N(N), .NREGS(NREGS), .NR(NR), .CW(2)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  // Behavioural model of the architectural state
  logic [N-1:0]     m_regs [NREGS];
  logic [NREGS-1:0] m_busy;
  int               m_cnt;

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
    m_busy = '0;
    m_cnt  = 0;
  endtask

  function automatic logic [N-1:0] exp_data(input int i);
    int a;
    a = int'(bus.rd_addr[i]);
    if (a == 0) return '0;
    if (bus.wr_en && int'(bus.wr_addr) == a) return bus.wr_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_ready(input int i);
    int a;
    a = int'(bus.rd_addr[i]);
    if (a == 0) return 1'b1;
    if (bus.wr_en && int'(bus.wr_addr) == a) return 1'b1;
    return !m_busy[a];
  endfunction

  function automatic logic exp_stall();
    for (int i = 0; i < NR; i++)
      if (bus.rd_en[i] && !exp_ready(i)) return 1'b1;
    return 1'b0;
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge; returns at the negedge.
  task automatic tick();
    logic             s;
    logic [NREGS-1:0] nb;
    @(posedge clk);
    if (rst) begin
      s = exp_stall();
      if (bus.wr_en && bus.wr_addr != 0) m_regs[bus.wr_addr] = bus.wr_data;
      nb = m_busy;
      if (bus.wr_en)    nb[bus.wr_addr]    = 1'b0;
      if (bus.issue_en) nb[bus.issue_addr] = 1'b1;
      if (bus.flush)    nb = '0;
      nb[0] = 1'b0;
      m_busy = nb;
      if (s && m_cnt < CMAX) m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.rd_en      = '0;
    bus.rd_addr    = '0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.issue_en   = 1'b0;
    bus.issue_addr = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic idle2();
    bus2.rd_en      = '0;
    bus2.rd_addr    = '0;
    bus2.wr_en      = 1'b0;
    bus2.wr_addr    = '0;
    bus2.wr_data    = '0;
    bus2.issue_en   = 1'b0;
    bus2.issue_addr = '0;
    bus2.flush      = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.rd_en      = 2'b11;
    bus.rd_addr[0] = 5'($urandom_range(1, 31));
    bus.rd_addr[1] = 5'($urandom_range(1, 31));
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", bus.stall); end
    checks++; if (bus.rd_ready !== 2'b11) begin failures++; $display("FAIL reset_ready got=%b exp=11", bus.rd_ready); end
    checks++; if (bus.busy_vec !== '0) begin failures++; $display("FAIL reset_busy got=%h exp=0", bus.busy_vec); end
    checks++; if (bus.stall_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt); end
    checks++; if (bus.rd_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.rd_data); end
    @(negedge clk);
    rst  = 1'b1;
    rst2 = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_write_read();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
    tick();
    idle();
    bus.rd_en[0] = 1'b1; bus.rd_addr[0] = 5'd5;
    #1;
    checks++; if (bus.rd_data[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_data got=%h exp=deadbeef", bus.rd_data[0]); end
    checks++; if (bus.rd_ready[0] !== 1'b1) begin failures++; $display("FAIL wr_rd_ready got=%0b exp=1", bus.rd_ready[0]); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL wr_rd_stall got=%0b exp=0", bus.stall); end
    tick();
    idle();
  endtask

  task automatic test_bypass();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h1234;
    bus.rd_en[1] = 1'b1; bus.rd_addr[1] = 5'd7;
    #1;
    checks++; if (bus.rd_data[1] !== 32'h1234) begin failures++; $display("FAIL bypass_data got=%h exp=1234", bus.rd_data[1]); end
    checks++; if (bus.rd_ready[1] !== 1'b1) begin failures++; $display("FAIL bypass_ready got=%0b exp=1", bus.rd_ready[1]); end
    tick();
    bus.wr_en = 1'b0; bus.wr_data = 32'hFFFF_0000;
    #1;
    checks++; if (bus.rd_data[1] !== 32'h1234) begin failures++; $display("FAIL stored_data got=%h exp=1234", bus.rd_data[1]); end
    tick();
    idle();
  endtask

  task automatic test_scoreboard();
    int base;
    base = m_cnt;
    bus.issue_en = 1'b1; bus.issue_addr = 5'd3;
    #1;
    checks++; if (bus.busy_vec[3] !== 1'b0) begin failures++; $display("FAIL issue_latency got=%0b exp=0", bus.busy_vec[3]); end
    tick();
    idle();
    bus.rd_en[0] = 1'b1; bus.rd_addr[0] = 5'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL sb_stall[%0d] got=%0b exp=1", k, bus.stall); end
      checks++; if (bus.rd_ready[0] !== 1'b0) begin failures++; $display("FAIL sb_ready[%0d] got=%0b exp=0", k, bus.rd_ready[0]); end
      tick();
    end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h55;
    #1;
    checks++; if (bus.rd_ready[0] !== 1'b1) begin failures++; $display("FAIL sb_wb_ready got=%0b exp=1", bus.rd_ready[0]); end
    checks++; if (bus.rd_data[0] !== 32'h55) begin failures++; $display("FAIL sb_wb_data got=%h exp=55", bus.rd_data[0]); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL sb_wb_stall got=%0b exp=0", bus.stall); end
    checks++; if (int'(bus.stall_cnt) !== base + 3) begin failures++; $display("FAIL sb_cnt got=%0d exp=%0d", bus.stall_cnt, base + 3); end
    tick();
    idle();
    #1;
    checks++; if (bus.busy_vec[3] !== 1'b0) begin failures++; $display("FAIL sb_cleared got=%0b exp=0", bus.busy_vec[3]); end
  endtask

  task automatic test_issue_priority();
    bus.issue_en = 1'b1; bus.issue_addr = 5'd4;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'hCAFE;
    tick();
    idle();
    bus.rd_en[1] = 1'b1; bus.rd_addr[1] = 5'd4;
    #1;
    checks++; if (bus.busy_vec[4] !== 1'b1) begin failures++; $display("FAIL issue_beats_wr got=%0b exp=1", bus.busy_vec[4]); end
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL issue_beats_wr_stall got=%0b exp=1", bus.stall); end
    bus.rd_en = '0;
    bus.issue_en = 1'b1; bus.issue_addr = 5'd6; bus.flush = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (bus.busy_vec[6] !== 1'b0) begin failures++; $display("FAIL flush_beats_issue got=%0b exp=0", bus.busy_vec[6]); end
    checks++; if (bus.busy_vec !== '0) begin failures++; $display("FAIL flush_all got=%h exp=0", bus.busy_vec); end
  endtask

  task automatic test_reg0();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFF;
    bus.issue_en = 1'b1; bus.issue_addr = 5'd0;
    bus.rd_en = 2'b11; bus.rd_addr[0] = 5'd0; bus.rd_addr[1] = 5'd0;
    #1;
    checks++; if (bus.rd_data[0] !== '0) begin failures++; $display("FAIL r0_no_bypass got=%h exp=0", bus.rd_data[0]); end
    tick();
    idle();
    bus.rd_en = 2'b11;
    #1;
    checks++; if (bus.rd_data !== '0) begin failures++; $display("FAIL r0_data got=%h exp=0", bus.rd_data); end
    checks++; if (bus.busy_vec[0] !== 1'b0) begin failures++; $display("FAIL r0_busy got=%0b exp=0", bus.busy_vec[0]); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL r0_stall got=%0b exp=0", bus.stall); end
    tick();
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.rd_en      = 2'($urandom);
      bus.rd_addr[0] = 5'($urandom_range(0, 9));
      bus.rd_addr[1] = 5'($urandom_range(0, 9));
      bus.wr_en      = ($urandom_range(0, 1) == 1);
      bus.wr_addr    = 5'($urandom_range(0, 9));
      bus.wr_data    = $urandom;
      bus.issue_en   = ($urandom_range(0, 4) == 0);
      bus.issue_addr = 5'($urandom_range(0, 9));
      bus.flush      = ($urandom_range(0, 19) == 0);
      #1;
      for (int i = 0; i < NR; i++) begin
        checks++; if (bus.rd_data[i] !== exp_data(i)) begin failures++; $display("FAIL rnd_data[%0d] cyc=%0d got=%h exp=%h", i, c, bus.rd_data[i], exp_data(i)); end
        checks++; if (bus.rd_ready[i] !== exp_ready(i)) begin failures++; $display("FAIL rnd_ready[%0d] cyc=%0d got=%0b exp=%0b", i, c, bus.rd_ready[i], exp_ready(i)); end
      end
      checks++; if (bus.stall !== exp_stall()) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", c, bus.stall, exp_stall()); end
      checks++; if (bus.busy_vec !== m_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", c, bus.busy_vec, m_busy); end
      checks++; if (int'(bus.stall_cnt) !== m_cnt) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, bus.stall_cnt, m_cnt); end
      tick();
    end
    idle();
  endtask

  task automatic test_saturate_and_reset();
    bus2.issue_en = 1'b1; bus2.issue_addr = 5'd3;
    tick();
    idle2();
    bus2.rd_en[0] = 1'b1; bus2.rd_addr[0] = 5'd3;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (bus2.stall !== 1'b1) begin failures++; $display("FAIL sat_stall[%0d] got=%0b exp=1", k, bus2.stall); end
      tick();
    end
    #1;
    checks++; if (bus2.stall_cnt !== 2'd3) begin failures++; $display("FAIL sat_cnt got=%0d exp=3", bus2.stall_cnt); end
    #2;
    rst2 = 1'b0;
    #1;
    checks++; if (bus2.stall_cnt !== 2'd0) begin failures++; $display("FAIL rst_mid_cnt got=%0d exp=0", bus2.stall_cnt); end
    checks++; if (bus2.busy_vec !== '0) begin failures++; $display("FAIL rst_mid_busy got=%h exp=0", bus2.busy_vec); end
    checks++; if (bus2.stall !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%0b exp=0", bus2.stall); end
    @(negedge clk);
    rst2 = 1'b1;
    idle2();
  endtask

  task automatic test_reset_main_mid();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'hA5A5_5A5A;
    tick();
    idle();
    bus.issue_en = 1'b1; bus.issue_addr = 5'd9;
    tick();
    idle();
    bus.rd_en[0] = 1'b1; bus.rd_addr[0] = 5'd9;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL pre_rst_stall got=%0b exp=1", bus.stall); end
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL main_rst_stall got=%0b exp=0", bus.stall); end
    checks++; if (bus.rd_data[0] !== '0) begin failures++; $display("FAIL main_rst_data got=%h exp=0", bus.rd_data[0]); end
    checks++; if (bus.busy_vec !== '0) begin failures++; $display("FAIL main_rst_busy got=%h exp=0", bus.busy_vec); end
    checks++; if (bus.stall_cnt !== '0) begin failures++; $display("FAIL main_rst_cnt got=%0d exp=0", bus.stall_cnt); end
    @(negedge clk);
    rst = 1'b1;
    idle();
    tick();
  endtask

  initial begin
    idle();
    idle2();
    model_reset();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_issue_priority();
    test_reg0();
    test_random();
    test_saturate_and_reset();
    test_reset_main_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
